core: RTL and testbench

// - One SIMT compute core: runs one block of up to THREADS_PER_BLOCK threads in lockstep, shared PC + active mask.
// - Fetches 16-bit instructions from program memory; coalesces per-thread loads/stores onto one data-memory port.
// - Handles branch divergence with SSYN (split) and SYNC (reconverge). Instantiated once per block slot by the dispatcher.

---
 rtl/core.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_core.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core.sv
// rtl/core.sv - SIMT compute core, lockstep lanes with divergence stack; MUL/DIV enabled by CORE_MULDIV_EN
module core #(
    parameter int DATA_MEM_ADDR_BITS        = 8,
    parameter int DATA_MEM_DATA_BITS        = 8,
    parameter int PROGRAM_MEM_ADDR_BITS     = 8,
    parameter int PROGRAM_MEM_DATA_BITS     = 16,
    parameter int THREADS_PER_BLOCK         = 4,
    parameter int PROGRAM_MEM_DATA_READ_NUM = 4,
    parameter int DATA_MEM_DATA_READ_NUM    = 4,
    parameter int DIV_STACK_DEPTH           = 4
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic                                                        start,
    output logic                                                        done,
    input  logic [7:0]                                                  block_id,
    input  logic [$clog2(THREADS_PER_BLOCK):0]                          thread_count,
    output logic                                                        program_mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                            program_mem_read_address,
    input  logic                                                        program_mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_READ_NUM*PROGRAM_MEM_DATA_BITS-1:0]  program_mem_read_data,
    output logic                                                        data_mem_read_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                               data_mem_read_address,
    input  logic                                                        data_mem_read_ready,
    input  logic [DATA_MEM_DATA_READ_NUM*DATA_MEM_DATA_BITS-1:0]        data_mem_read_data,
    output logic                                                        data_mem_write_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                               data_mem_write_address,
    output logic [DATA_MEM_DATA_BITS-1:0]                               data_mem_write_data,
    input  logic                                                        data_mem_write_ready
);
    localparam int T   = THREADS_PER_BLOCK;
    localparam int LW  = $clog2(T);
    localparam int TCW = LW + 1;
    localparam int DW  = DATA_MEM_DATA_BITS;
    localparam int AW  = DATA_MEM_ADDR_BITS;
    localparam int PW  = PROGRAM_MEM_ADDR_BITS;
    localparam int IW  = PROGRAM_MEM_DATA_BITS;
    localparam int PRN = PROGRAM_MEM_DATA_READ_NUM;
    localparam int DRN = DATA_MEM_DATA_READ_NUM;
    localparam int PIW = $clog2(PRN);
    localparam int DIW = $clog2(DRN);
    localparam int SD  = DIV_STACK_DEPTH;
    localparam int SIW = $clog2(SD);
    localparam int SPW = SIW + 1;
    localparam logic [PW-1:0]  L_PRN = PW'(PRN);
    localparam logic [AW-1:0]  L_DRN = AW'(DRN);
    localparam logic [SPW-1:0] L_SD  = SPW'(SD);

    localparam logic [3:0] OP_CMP   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
`ifdef CORE_MULDIV_EN
    localparam logic [3:0] OP_MUL   = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
`endif
    localparam logic [3:0] OP_LDR   = 4'h7;
    localparam logic [3:0] OP_STR   = 4'h8;
    localparam logic [3:0] OP_CONST = 4'h9;
    localparam logic [3:0] OP_SSYN  = 4'hB;
    localparam logic [3:0] OP_SYNC  = 4'hC;
    localparam logic [3:0] OP_JUMP  = 4'hD;
    localparam logic [3:0] OP_RET   = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_REQUEST, S_WAIT, S_EXECUTE, S_UPDATE, S_DONE
    } state_t;

    state_t                 r_state, w_next;
    logic [PW-1:0]          r_pc, r_buf_base, r_pm_addr;
    logic                   r_buf_valid;
    logic [IW-1:0]          r_buf [PRN];
    logic [IW-1:0]          r_instr;
    logic [T-1:0]           r_mask, r_pend;
    logic [12:0][DW-1:0]    r_regs [T];
    logic [2:0]             r_nzp [T];
    logic [DW-1:0]          r_ld_val [T];
    logic [PW-1:0]          r_stk_pc [SD];
    logic [T-1:0]           r_stk_mask [SD];
    logic [SPW-1:0]         r_sp;
    logic                   r_pm_valid, r_pm_hold;
    logic                   r_dr_valid, r_dr_hold;
    logic [AW-1:0]          r_dr_addr;
    logic                   r_dw_valid, r_dw_hold;
    logic [AW-1:0]          r_dw_addr;
    logic [DW-1:0]          r_dw_data;

    logic [3:0]             w_op, w_rd, w_rs, w_rt;
    logic [7:0]             w_imm;
    logic [2:0]             w_cond;
    logic [PW-1:0]          w_off, w_imm_pc;
    logic                   w_in_buf, w_wb, w_stk_ne, w_reentry;
    logic [T-1:0]           w_tc_mask, w_active, w_pass, w_ld_hit;
    logic [DW-1:0]          w_rs_val [T];
    logic [DW-1:0]          w_rt_val [T];
    logic [DW-1:0]          w_alu [T];
    logic [AW-1:0]          w_addr [T];
    logic [AW-1:0]          w_ld_off [T];
    logic [AW-1:0]          w_ld_base;
    logic [LW-1:0]          w_st_lane;
    logic [DW-1:0]          w_dr_word [DRN];
    logic [IW-1:0]          w_pm_word [PRN];
    logic [SIW-1:0]         w_top_idx;
    logic [PW-1:0]          w_top_pc;
    logic [T-1:0]           w_top_mask;

    // R13-R15 are read-only views of block id, thread count and lane index
    function automatic logic [DW-1:0] f_read(input logic [12:0][DW-1:0] row, input logic [3:0] idx,
                                             input logic [DW-1:0] bid, input logic [DW-1:0] tcv,
                                             input logic [DW-1:0] lane_id);
        case (idx)
            4'd13:   f_read = bid;
            4'd14:   f_read = tcv;
            4'd15:   f_read = lane_id;
            default: f_read = row[idx];
        endcase
    endfunction

    assign w_op       = r_instr[15:12];
    assign w_rd       = r_instr[11:8];
    assign w_rs       = r_instr[7:4];
    assign w_rt       = r_instr[3:0];
    assign w_imm      = r_instr[7:0];
    assign w_imm_pc   = PW'(w_imm);
    assign w_cond     = {r_instr[9], r_instr[10], r_instr[8]};
    assign w_off      = r_pc - r_buf_base;
    assign w_in_buf   = r_buf_valid && (w_off < L_PRN);
    assign w_active   = r_mask & w_tc_mask;
    assign w_stk_ne   = (r_sp != '0);
    assign w_top_idx  = SIW'(r_sp - SPW'(1));
    assign w_top_pc   = r_stk_pc[w_top_idx];
    assign w_top_mask = r_stk_mask[w_top_idx];
    assign w_reentry  = w_stk_ne && (w_top_pc == w_imm_pc);

    assign done                     = (r_state == S_DONE);
    assign program_mem_read_valid   = r_pm_valid;
    assign program_mem_read_address = r_pm_addr;
    assign data_mem_read_valid      = r_dr_valid;
    assign data_mem_read_address    = r_dr_addr;
    assign data_mem_write_valid     = r_dw_valid;
    assign data_mem_write_address   = r_dw_addr;
    assign data_mem_write_data      = r_dw_data;

    // Per-lane operand read, branch condition and load coalescing window
    always_comb begin
        w_ld_base = '1;
        w_st_lane = '0;
        for (int l = 0; l < T; l++) begin
            w_tc_mask[l] = (TCW'(l) < thread_count);
            w_rs_val[l]  = f_read(r_regs[l], w_rs, DW'(block_id), DW'(thread_count), DW'(l));
            w_rt_val[l]  = f_read(r_regs[l], w_rt, DW'(block_id), DW'(thread_count), DW'(l));
            w_addr[l]    = AW'(w_rs_val[l]);
            w_ld_off[l]  = w_addr[l] - r_dr_addr;
            w_ld_hit[l]  = r_pend[l] && (w_ld_off[l] < L_DRN);
            w_pass[l]    = w_active[l] && ((w_cond & r_nzp[l]) != 3'b000);
            if (r_pend[l] && (w_addr[l] < w_ld_base)) w_ld_base = w_addr[l];
        end
        for (int l = T - 1; l >= 0; l--) begin
            if (r_pend[l]) w_st_lane = LW'(l);
        end
        for (int j = 0; j < DRN; j++) w_dr_word[j] = data_mem_read_data[j*DW +: DW];
        for (int j = 0; j < PRN; j++) w_pm_word[j] = program_mem_read_data[j*IW +: IW];
    end

    // Per-lane result of the current instruction and whether it writes rd
    always_comb begin
        w_wb = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_LDR, OP_CONST: w_wb = 1'b1;
`ifdef CORE_MULDIV_EN
            OP_MUL, OP_DIV:                   w_wb = 1'b1;
`endif
            default:                          w_wb = 1'b0;
        endcase
        for (int l = 0; l < T; l++) begin
            w_alu[l] = '0;
            case (w_op)
                OP_ADD:   w_alu[l] = w_rs_val[l] + w_rt_val[l];
                OP_SUB:   w_alu[l] = w_rs_val[l] - w_rt_val[l];
                OP_LDR:   w_alu[l] = r_ld_val[l];
                OP_CONST: w_alu[l] = DW'(w_imm);
`ifdef CORE_MULDIV_EN
                OP_MUL:   w_alu[l] = w_rs_val[l] * w_rt_val[l];
                OP_DIV:   w_alu[l] = (w_rt_val[l] == '0) ? '1 : w_rs_val[l] / w_rt_val[l];
`endif
                default:  w_alu[l] = '0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: memory phases advance only once their handshakes complete
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_FETCH;
            S_FETCH:   if (w_in_buf || (r_pm_valid && program_mem_read_ready)) w_next = S_DECODE;
            S_DECODE:  w_next = S_REQUEST;
            S_REQUEST: w_next = S_WAIT;
            S_WAIT:    if ((r_pend == '0) && !r_dr_valid && !r_dw_valid) w_next = S_EXECUTE;
            S_EXECUTE: w_next = S_UPDATE;
            S_UPDATE:  w_next = (w_op == OP_RET) ? S_DONE : S_FETCH;
            S_DONE:    w_next = S_DONE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath: fetch buffer, memory handshakes, register writeback, PC/mask/stack
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc        <= '0;
            r_buf_base  <= '0;
            r_buf_valid <= 1'b0;
            r_instr     <= '0;
            r_mask      <= '0;
            r_pend      <= '0;
            r_sp        <= '0;
            r_pm_valid  <= 1'b0;
            r_pm_hold   <= 1'b0;
            r_pm_addr   <= '0;
            r_dr_valid  <= 1'b0;
            r_dr_hold   <= 1'b0;
            r_dr_addr   <= '0;
            r_dw_valid  <= 1'b0;
            r_dw_hold   <= 1'b0;
            r_dw_addr   <= '0;
            r_dw_data   <= '0;
            for (int j = 0; j < PRN; j++) r_buf[j] <= '0;
            for (int s = 0; s < SD; s++) begin
                r_stk_pc[s]   <= '0;
                r_stk_mask[s] <= '0;
            end
            for (int l = 0; l < T; l++) begin
                r_regs[l]   <= '0;
                r_nzp[l]    <= '0;
                r_ld_val[l] <= '0;
            end
        end else begin
            // a port may issue again only after its ready has been seen low
            if (!program_mem_read_ready) r_pm_hold <= 1'b0;
            if (!data_mem_read_ready)    r_dr_hold <= 1'b0;
            if (!data_mem_write_ready)   r_dw_hold <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc        <= '0;
                        r_mask      <= w_tc_mask;
                        r_buf_valid <= 1'b0;
                        r_sp        <= '0;
                        for (int l = 0; l < T; l++) begin
                            r_regs[l] <= '0;
                            r_nzp[l]  <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    if (!w_in_buf) begin
                        if (r_pm_valid) begin
                            if (program_mem_read_ready) begin
                                for (int j = 0; j < PRN; j++) r_buf[j] <= w_pm_word[j];
                                r_buf_base  <= r_pm_addr;
                                r_buf_valid <= 1'b1;
                                r_pm_valid  <= 1'b0;
                                r_pm_hold   <= 1'b1;
                            end
                        end else if (!r_pm_hold) begin
                            r_pm_valid <= 1'b1;
                            r_pm_addr  <= r_pc;
                        end
                    end
                end
                S_DECODE:  r_instr <= r_buf[w_off[PIW-1:0]];
                S_REQUEST: r_pend  <= ((w_op == OP_LDR) || (w_op == OP_STR)) ? w_active : '0;
                S_WAIT: begin
                    if (w_op == OP_LDR) begin
                        if (r_dr_valid) begin
                            if (data_mem_read_ready) begin
                                for (int l = 0; l < T; l++) begin
                                    if (w_ld_hit[l]) begin
                                        r_ld_val[l] <= w_dr_word[w_ld_off[l][DIW-1:0]];
                                        r_pend[l]   <= 1'b0;
                                    end
                                end
                                r_dr_valid <= 1'b0;
                                r_dr_hold  <= 1'b1;
                            end
                        end else if ((r_pend != '0) && !r_dr_hold) begin
                            r_dr_valid <= 1'b1;
                            r_dr_addr  <= w_ld_base;
                        end
                    end else if (w_op == OP_STR) begin
                        if (r_dw_valid) begin
                            if (data_mem_write_ready) begin
                                r_pend[w_st_lane] <= 1'b0;
                                r_dw_valid        <= 1'b0;
                                r_dw_hold         <= 1'b1;
                            end
                        end else if ((r_pend != '0) && !r_dw_hold) begin
                            r_dw_valid <= 1'b1;
                            r_dw_addr  <= w_addr[w_st_lane];
                            r_dw_data  <= w_rt_val[w_st_lane];
                        end
                    end
                end
                S_EXECUTE: begin
                    for (int l = 0; l < T; l++) begin
                        if (w_active[l]) begin
                            if (w_wb && (w_rd < 4'd13)) r_regs[l][w_rd] <= w_alu[l];
                            if (w_op == OP_CMP)
                                r_nzp[l] <= {w_rs_val[l] < w_rt_val[l], w_rs_val[l] == w_rt_val[l],
                                             w_rs_val[l] > w_rt_val[l]};
                        end
                    end
                end
                S_UPDATE: begin
                    case (w_op)
                        OP_SSYN: begin
                            if (w_pass == '0) begin
                                r_pc <= w_imm_pc;
                            end else begin
                                r_pc   <= r_pc + PW'(1);
                                r_mask <= w_pass;
                                if (!w_reentry && (r_sp < L_SD)) begin
                                    r_stk_pc[r_sp[SIW-1:0]]   <= w_imm_pc;
                                    r_stk_mask[r_sp[SIW-1:0]] <= r_mask;
                                    r_sp                      <= r_sp + SPW'(1);
                                end
                            end
                        end
                        OP_SYNC: begin
                            if (w_stk_ne && (w_top_pc == r_pc)) begin
                                r_mask <= w_top_mask;
                                r_sp   <= r_sp - SPW'(1);
                            end
                            r_pc <= r_pc + PW'(1);
                        end
                        OP_JUMP: r_pc <= w_imm_pc;
                        OP_RET:  r_pc <= r_pc;
                        default: r_pc <= r_pc + PW'(1);
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_core.sv
// tb/tb_core.sv - scoreboard bench for core: memory responders, write monitor, directed kernels
module tb_core;
    logic        clk = 1'b0;
    logic        reset, start, done;
    logic [7:0]  block_id;
    logic [2:0]  thread_count;
    logic        program_mem_read_valid, program_mem_read_ready;
    logic [7:0]  program_mem_read_address;
    logic [63:0] program_mem_read_data;
    logic        data_mem_read_valid, data_mem_read_ready;
    logic [7:0]  data_mem_read_address;
    logic [31:0] data_mem_read_data;
    logic        data_mem_write_valid, data_mem_write_ready;
    logic [7:0]  data_mem_write_address, data_mem_write_data;

    logic [15:0] pmem [256];
    logic [7:0]  dmem [256];
    logic [15:0] exp_q [$];
    int          checks = 0, errors = 0, rd_txn = 0, wr_txn = 0;

    logic [15:0] prog_sq  [13] = '{16'h70F0, 16'h9201, 16'h9404, 16'h344F, 16'h2010, 16'hB209, 16'h3330,
                                   16'h3112, 16'hD004, 16'hC000, 16'hC000, 16'h8043, 16'hF000};
    logic [15:0] prog_uni [10] = '{16'h9005, 16'h2000, 16'hB205, 16'h9111, 16'hF000, 16'hC000, 16'h9220,
                                   16'h322F, 16'h8021, 16'hF000};
    logic [15:0] prog_md  [13] = '{16'h9507, 16'h9609, 16'h5756, 16'h6860, 16'h9930, 16'h8097, 16'h9A01,
                                   16'h399A, 16'h8098, 16'h9D55, 16'h399A, 16'h809D, 16'hF000};

    core dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .block_id(block_id), .thread_count(thread_count),
        .program_mem_read_valid(program_mem_read_valid), .program_mem_read_address(program_mem_read_address),
        .program_mem_read_ready(program_mem_read_ready), .program_mem_read_data(program_mem_read_data),
        .data_mem_read_valid(data_mem_read_valid), .data_mem_read_address(data_mem_read_address),
        .data_mem_read_ready(data_mem_read_ready), .data_mem_read_data(data_mem_read_data),
        .data_mem_write_valid(data_mem_write_valid), .data_mem_write_address(data_mem_write_address),
        .data_mem_write_data(data_mem_write_data), .data_mem_write_ready(data_mem_write_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // program memory responder
    initial begin
        logic [7:0] a;
        program_mem_read_ready = 1'b0;
        program_mem_read_data  = '0;
        forever begin
            @(posedge clk); #2;
            if (program_mem_read_ready) program_mem_read_ready = 1'b0;
            else if (program_mem_read_valid) begin
                for (int i = 0; i < 4; i++) begin
                    a = program_mem_read_address + 8'(i);
                    program_mem_read_data[16*i +: 16] = pmem[a];
                end
                program_mem_read_ready = 1'b1;
            end
        end
    end

    // data read responder
    initial begin
        logic [7:0] a;
        data_mem_read_ready = 1'b0;
        data_mem_read_data  = '0;
        forever begin
            @(posedge clk); #2;
            if (data_mem_read_ready) data_mem_read_ready = 1'b0;
            else if (data_mem_read_valid) begin
                for (int i = 0; i < 4; i++) begin
                    a = data_mem_read_address + 8'(i);
                    data_mem_read_data[8*i +: 8] = dmem[a];
                end
                data_mem_read_ready = 1'b1;
                rd_txn++;
            end
        end
    end

    // data write responder
    initial begin
        data_mem_write_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (data_mem_write_ready) data_mem_write_ready = 1'b0;
            else if (data_mem_write_valid) begin
                dmem[data_mem_write_address] = data_mem_write_data;
                data_mem_write_ready = 1'b1;
                wr_txn++;
            end
        end
    end

    // write monitor: every accepted store is matched against the scoreboard queue
    always @(negedge clk) begin
        logic [15:0] e;
        if (data_mem_write_valid && data_mem_write_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write",
                         data_mem_write_address, data_mem_write_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {24'h0, data_mem_write_address}, {24'h0, e[15:8]});
                check("wr_data", {24'h0, data_mem_write_data}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic pulse_reset(input string name);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "_rst_done"}, {31'h0, done}, 32'h0);
        check({name, "_rst_pm_valid"}, {31'h0, program_mem_read_valid}, 32'h0);
        check({name, "_rst_dr_valid"}, {31'h0, data_mem_read_valid}, 32'h0);
        check({name, "_rst_dw_valid"}, {31'h0, data_mem_write_valid}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        rd_txn = 0;
        wr_txn = 0;
    endtask

    task automatic run_kernel(input string name);
        int n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, {31'h0, done}, 32'h1);
        repeat (4) @(negedge clk);
        check({name, "_sb_left"}, exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    task automatic load_square;
        foreach (pmem[i]) pmem[i] = 16'h0000;
        foreach (prog_sq[i]) pmem[i] = prog_sq[i];
        for (int i = 0; i < 4; i++) begin
            dmem[i]     = 8'(i + 1);
            dmem[i + 4] = 8'h00;
        end
    endtask

    task automatic push_square(input int lanes);
        for (int i = 0; i < lanes; i++) exp_q.push_back({8'(4 + i), 8'((i + 1) * (i + 1))});
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        block_id = 8'h2A;
        thread_count = 3'd4;
        foreach (dmem[i]) dmem[i] = 8'h00;
        foreach (pmem[i]) pmem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_pm_valid", {31'h0, program_mem_read_valid}, 32'h0);
        check("reset_dr_valid", {31'h0, data_mem_read_valid}, 32'h0);
        check("reset_dw_valid", {31'h0, data_mem_write_valid}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // square kernel, all four lanes
        load_square();
        push_square(4);
        run_kernel("sq4");
        for (int i = 0; i < 4; i++) check($sformatf("sq4_mem%0d", 4 + i), {24'h0, dmem[4 + i]}, (i + 1) * (i + 1));
        check("sq4_writes", wr_txn, 4);
        check("sq4_reads", rd_txn, 1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        check("sq4_start_in_done", {31'h0, done}, 32'h1);
        check("sq4_no_rerun_writes", wr_txn, 4);

        // square kernel, two lanes
        pulse_reset("tc2");
        thread_count = 3'd2;
        load_square();
        push_square(2);
        run_kernel("sq2");
        check("sq2_mem4", {24'h0, dmem[4]}, 1);
        check("sq2_mem5", {24'h0, dmem[5]}, 4);
        check("sq2_mem6", {24'h0, dmem[6]}, 0);
        check("sq2_mem7", {24'h0, dmem[7]}, 0);
        check("sq2_writes", wr_txn, 2);
        check("sq2_reads", rd_txn, 1);

        // uniform SSYN jump, SYNC on empty stack, three lanes
        pulse_reset("uni");
        thread_count = 3'd3;
        foreach (pmem[i]) pmem[i] = 16'h0000;
        foreach (prog_uni[i]) pmem[i] = prog_uni[i];
        for (int i = 0; i < 4; i++) dmem[8'h20 + i] = 8'hEE;
        for (int i = 0; i < 3; i++) exp_q.push_back({8'(8'h20 + i), 8'h00});
        run_kernel("uni");
        check("uni_writes", wr_txn, 3);
        check("uni_mem20", {24'h0, dmem[8'h20]}, 0);
        check("uni_mem23", {24'h0, dmem[8'h23]}, 32'hEE);

        // MUL/DIV, read-only R13, single lane
        pulse_reset("md");
        thread_count = 3'd1;
        foreach (pmem[i]) pmem[i] = 16'h0000;
        foreach (prog_md[i]) pmem[i] = prog_md[i];
`ifdef CORE_MULDIV_EN
        exp_q.push_back({8'h30, 8'h3F});
        exp_q.push_back({8'h31, 8'hFF});
`else
        exp_q.push_back({8'h30, 8'h00});
        exp_q.push_back({8'h31, 8'h00});
`endif
        exp_q.push_back({8'h32, 8'h2A});
        run_kernel("md");
        check("md_writes", wr_txn, 3);

        // reset in the middle of the loop, then a full rerun
        pulse_reset("mid");
        thread_count = 3'd4;
        load_square();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (80) @(negedge clk);
        check("mid_not_done", {31'h0, done}, 32'h0);
        check("mid_no_writes", wr_txn, 0);
        pulse_reset("mid2");
        for (int i = 4; i < 8; i++) dmem[i] = 8'h00;
        push_square(4);
        n = 0;
        run_kernel("rerun");
        for (int i = 0; i < 4; i++) check($sformatf("rerun_mem%0d", 4 + i), {24'h0, dmem[4 + i]}, (i + 1) * (i + 1));
        check("rerun_writes", wr_txn, 4);
        check("rerun_reads", rd_txn, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
